// File: rtl/sdram_init_sequencer_if.sv
// SDRAM command bus plus refresh-request handshake shared by the init sequencer (master)
// and the SDRAM controller (slave).
interface sdram_init_sequencer_if;
   logic        cke;
   logic        cs_n;
   logic        ras_n;
   logic        cas_n;
   logic        we_n;
   logic [12:0] a;
   logic [1:0]  ba;
   logic        init_done;
   logic        ref_req;
   logic        ref_ack;
   logic        ref_overrun;

   modport master (
      output cke, cs_n, ras_n, cas_n, we_n, a, ba,
      output init_done, ref_req, ref_overrun,
      input  ref_ack
   );

   modport slave (
      input  cke, cs_n, ras_n, cas_n, we_n, a, ba,
      input  init_done, ref_req, ref_overrun,
      output ref_ack
   );
endinterface

// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up sequencer: waits for PLL lock, issues PRECHARGE ALL, N x AUTO REFRESH and
// LOAD MODE, then paces refresh requests. Define SDRAM_INIT_LOCK_WATCH_EN to restart on lock loss.
module sdram_init_sequencer #(
   parameter int          CLK_FREQ_MHZ   = 100,
   parameter int          T_INIT_US      = 200,
   parameter int          T_RP_CYC       = 2,
   parameter int          T_RFC_CYC      = 7,
   parameter int          T_MRD_CYC      = 2,
   parameter int          N_REFRESH      = 8,
   parameter logic [12:0] MODE_REG       = 13'h0037,
   parameter int          REF_PERIOD_CYC = 780
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pll_locked,
   sdram_init_sequencer_if.master bus
);

   localparam int INIT_CYC = CLK_FREQ_MHZ * T_INIT_US;
   localparam int CNT_W    = $clog2(INIT_CYC + 1);
   localparam int REF_W    = $clog2(N_REFRESH + 1);
   localparam int TMR_W    = $clog2(REF_PERIOD_CYC + 1);

   // The command cycle counts as the first cycle of its tXX interval, so the wait state
   // loads T-2 and an interval of 1 skips the wait state entirely.
   localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYC - 1);
   localparam logic [CNT_W-1:0] RP_LOAD   = CNT_W'((T_RP_CYC  >= 2) ? T_RP_CYC  - 2 : 0);
   localparam logic [CNT_W-1:0] RFC_LOAD  = CNT_W'((T_RFC_CYC >= 2) ? T_RFC_CYC - 2 : 0);
   localparam logic [CNT_W-1:0] MRD_LOAD  = CNT_W'((T_MRD_CYC >= 2) ? T_MRD_CYC - 2 : 0);
   localparam logic [REF_W-1:0] REF_TOTAL = REF_W'(N_REFRESH);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(REF_PERIOD_CYC - 1);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   typedef enum logic [3:0] {
      WAIT_LOCK,
      POWERUP,
      PRECHARGE,
      WAIT_RP,
      REFRESH,
      WAIT_RFC,
      LOAD_MODE,
      WAIT_MRD,
      DONE
   } state_t;

   logic             rst_meta_reg;
   logic             rst_sync_n_reg;
   logic             lock_meta_reg;
   logic             lock_sync_reg;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [REF_W-1:0] ref_cnt_reg, ref_cnt_next;
   logic [REF_W-1:0] ref_cnt_inc;
   logic [TMR_W-1:0] ref_timer_reg;
   logic             cke_reg, cke_next;
   logic [3:0]       cmd_reg, cmd_next;
   logic [12:0]      a_reg, a_next;
   logic             init_done_reg;
   logic             ref_req_reg;
   logic             ref_overrun_reg;
   logic             timer_run;
   logic             timer_wrap;

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_meta_reg   <= 1'b0;
         rst_sync_n_reg <= 1'b0;
      end else begin
         rst_meta_reg   <= 1'b1;
         rst_sync_n_reg <= rst_meta_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n_reg) begin
      if (!rst_sync_n_reg) begin
         lock_meta_reg <= 1'b0;
         lock_sync_reg <= 1'b0;
      end else begin
         lock_meta_reg <= pll_locked;
         lock_sync_reg <= lock_meta_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n_reg) begin
      if (!rst_sync_n_reg) begin
         state_reg     <= WAIT_LOCK;
         cnt_reg       <= '0;
         ref_cnt_reg   <= '0;
         cke_reg       <= 1'b0;
         cmd_reg       <= CMD_NOP;
         a_reg         <= '0;
         init_done_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         ref_cnt_reg   <= ref_cnt_next;
         cke_reg       <= cke_next;
         cmd_reg       <= cmd_next;
         a_reg         <= a_next;
         init_done_reg <= (state_next == DONE);
      end
   end

   assign ref_cnt_inc = ref_cnt_reg + 1'b1;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ref_cnt_next = ref_cnt_reg;
      cke_next     = 1'b1;
      cmd_next     = CMD_NOP;
      a_next       = '0;

      case (state_reg)
         WAIT_LOCK: begin
            if (lock_sync_reg) begin
               state_next = POWERUP;
               cnt_next   = INIT_LOAD;
            end
         end
         POWERUP: begin
            if (cnt_reg == '0) state_next = PRECHARGE;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         PRECHARGE: begin
            if (T_RP_CYC < 2) begin
               state_next = REFRESH;
            end else begin
               state_next = WAIT_RP;
               cnt_next   = RP_LOAD;
            end
         end
         WAIT_RP: begin
            if (cnt_reg == '0) state_next = REFRESH;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         REFRESH: begin
            ref_cnt_next = ref_cnt_inc;
            if (T_RFC_CYC < 2) begin
               state_next = (ref_cnt_inc == REF_TOTAL) ? LOAD_MODE : REFRESH;
            end else begin
               state_next = WAIT_RFC;
               cnt_next   = RFC_LOAD;
            end
         end
         WAIT_RFC: begin
            if (cnt_reg == '0) state_next = (ref_cnt_reg == REF_TOTAL) ? LOAD_MODE : REFRESH;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         LOAD_MODE: begin
            if (T_MRD_CYC < 2) begin
               state_next = DONE;
            end else begin
               state_next = WAIT_MRD;
               cnt_next   = MRD_LOAD;
            end
         end
         WAIT_MRD: begin
            if (cnt_reg == '0) state_next = DONE;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         DONE: begin
            state_next = DONE;
         end
         default: begin
            state_next = WAIT_LOCK;
         end
      endcase

`ifdef SDRAM_INIT_LOCK_WATCH_EN
      if ((state_reg != WAIT_LOCK) && !lock_sync_reg) begin
         state_next   = WAIT_LOCK;
         cnt_next     = '0;
         ref_cnt_next = '0;
      end
`endif

      // Outputs are decoded from the next state so the registered bus lines up with the state.
      case (state_next)
         WAIT_LOCK: cke_next = 1'b0;
         PRECHARGE: begin
            cmd_next   = CMD_PRE;
            a_next[10] = 1'b1;
         end
         REFRESH:   cmd_next = CMD_REF;
         LOAD_MODE: begin
            cmd_next = CMD_LMR;
            a_next   = MODE_REG;
         end
         default:   cmd_next = CMD_NOP;
      endcase
   end

   // The refresh timer only runs while the sequencer stays in DONE.
   assign timer_run  = (state_reg == DONE) && (state_next == DONE);
   assign timer_wrap = timer_run && (ref_timer_reg == TMR_LAST);

   always_ff @(posedge clk or negedge rst_sync_n_reg) begin
      if (!rst_sync_n_reg) begin
         ref_timer_reg   <= '0;
         ref_req_reg     <= 1'b0;
         ref_overrun_reg <= 1'b0;
      end else if (!timer_run) begin
         ref_timer_reg <= '0;
         ref_req_reg   <= 1'b0;
      end else begin
         ref_timer_reg <= timer_wrap ? '0 : ref_timer_reg + 1'b1;
         if (timer_wrap) begin
            ref_req_reg <= 1'b1;
            if (ref_req_reg && !bus.ref_ack) ref_overrun_reg <= 1'b1;
         end else if (bus.ref_ack) begin
            ref_req_reg <= 1'b0;
         end
      end
   end

   assign bus.cke         = cke_reg;
   assign bus.cs_n        = cmd_reg[3];
   assign bus.ras_n       = cmd_reg[2];
   assign bus.cas_n       = cmd_reg[1];
   assign bus.we_n        = cmd_reg[0];
   assign bus.a           = a_reg;
   assign bus.ba          = 2'b00;
   assign bus.init_done   = init_done_reg;
   assign bus.ref_req     = ref_req_reg;
   assign bus.ref_overrun = ref_overrun_reg;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Bench for sdram_init_sequencer with a 100-cycle power-up wait: a schedule-based model checked
// every cycle, plus hand-computed cycle/value pins for the documented timeline.
module tb_sdram_init_sequencer;

   localparam int          T_INIT   = 100;
   localparam int          T_RP     = 2;
   localparam int          T_RFC    = 7;
   localparam int          T_MRD    = 2;
   localparam int          N_REF    = 8;
   localparam int          PERIOD   = 780;
   localparam logic [12:0] MODE     = 13'h0037;
   localparam int          REL_PRE  = T_INIT;
   localparam int          REL_REF0 = REL_PRE + T_RP;
   localparam int          REL_LMR  = REL_REF0 + N_REF * T_RFC;
   localparam int          REL_DONE = REL_LMR + T_MRD;
   localparam int          MAXC     = 16384;
   localparam int          END_CYC  = 6260;
`ifdef SDRAM_INIT_LOCK_WATCH_EN
   localparam int          WATCH    = 1;
`else
   localparam int          WATCH    = 0;
`endif

   typedef struct {
      int c;
      int f;
      int v;
   } pin_t;

   logic clk = 1'b0;
   logic rst_n;
   logic pll_locked;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   lock_h [MAXC];
   bit   ack_h  [MAXC];
   pin_t pins   [$];

   sdram_init_sequencer_if bus ();

   sdram_init_sequencer #(
      .T_INIT_US (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .bus        (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int field_val(input int f);
      case (f)
         0:       return int'(bus.cke);
         1:       return int'({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n});
         2:       return int'(bus.a);
         3:       return int'(bus.init_done);
         4:       return int'(bus.ref_req);
         default: return int'(bus.ref_overrun);
      endcase
   endfunction

   task automatic add_pin(input int c, input int f, input int v);
      pin_t p;
      p.c = c;
      p.f = f;
      p.v = v;
      pins.push_back(p);
   endtask

   // Moves to the start of cycle n (just after its rising edge).
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ack(input int n);
      goto(n);
      bus.ref_ack = 1'b1;
      goto(n + 1);
      bus.ref_ack = 1'b0;
   endtask

   // Model: the sequence is a fixed schedule relative to the first CKE-high cycle; refresh
   // request/overrun follow the wrap/ack rules one cycle at a time.
   initial begin
      int          c, rel;
      bit          m_idle, m_req, m_ovr, m_done_prev;
      int          m_start, m_rst_rel;
      bit          sync_prev, done_now, wrap_prev;
      logic        e_cke, e_done;
      logic [3:0]  e_cmd, got_cmd;
      logic [12:0] e_a;
      m_idle = 1'b1; m_req = 1'b0; m_ovr = 1'b0; m_done_prev = 1'b0;
      m_start = 0; m_rst_rel = -1;
      forever begin
         @(negedge clk);
         c = cyc;
         if (c < MAXC) begin
            lock_h[c] = pll_locked;
            ack_h[c]  = bus.ref_ack;
            if (!rst_n) begin
               m_idle = 1'b1; m_req = 1'b0; m_ovr = 1'b0; m_done_prev = 1'b0;
               m_rst_rel = -1;
            end else begin
               if (m_rst_rel < 0) m_rst_rel = c;
               // Lock seen by the FSM in cycle c-1 is the pin value two cycles earlier.
               sync_prev = (c >= 3) && lock_h[c-3] && (c - 1 >= m_rst_rel + 4);
`ifdef SDRAM_INIT_LOCK_WATCH_EN
               if (!m_idle && (c - 1 >= m_start) && !sync_prev) m_idle = 1'b1;
`endif
               if (m_idle && sync_prev) begin
                  m_idle  = 1'b0;
                  m_start = c;
               end
               done_now = !m_idle && (c - m_start >= REL_DONE);
               if (done_now && m_done_prev) begin
                  wrap_prev = ((c - 1 - (m_start + REL_DONE)) % PERIOD) == PERIOD - 1;
                  if (wrap_prev) begin
                     if (m_req && !ack_h[c-1]) m_ovr = 1'b1;
                     m_req = 1'b1;
                  end else if (ack_h[c-1]) begin
                     m_req = 1'b0;
                  end
               end else begin
                  m_req = 1'b0;
               end
               m_done_prev = done_now;
            end

            e_cke = 1'b0; e_cmd = 4'b0111; e_a = '0; e_done = 1'b0;
            if (!m_idle) begin
               rel   = c - m_start;
               e_cke = 1'b1;
               if (rel == REL_PRE) begin
                  e_cmd = 4'b0010;
                  e_a   = 13'h0400;
               end else if (rel >= REL_REF0 && rel < REL_LMR && (rel - REL_REF0) % T_RFC == 0) begin
                  e_cmd = 4'b0001;
               end else if (rel == REL_LMR) begin
                  e_cmd = 4'b0000;
                  e_a   = MODE;
               end
               e_done = (rel >= REL_DONE);
            end

            got_cmd = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};
            n_cmp++;
            if ({bus.cke, got_cmd, bus.a, bus.ba, bus.init_done, bus.ref_req, bus.ref_overrun} !==
                {e_cke, e_cmd, e_a, 2'b00, e_done, m_req, m_ovr}) begin
               n_bad++;
               $display("FAIL outputs cycle %0d: got cke=%b cmd=%b a=%h ba=%b done=%b req=%b ovr=%b, want cke=%b cmd=%b a=%h ba=00 done=%b req=%b ovr=%b",
                        c, bus.cke, got_cmd, bus.a, bus.ba, bus.init_done, bus.ref_req, bus.ref_overrun,
                        e_cke, e_cmd, e_a, e_done, m_req, m_ovr);
            end

            foreach (pins[i]) begin
               if (pins[i].c == c) begin
                  n_cmp++;
                  if (field_val(pins[i].f) != pins[i].v) begin
                     n_bad++;
                     $display("FAIL pin cycle %0d field %0d: got %0h, want %0h",
                              c, pins[i].f, field_val(pins[i].f), pins[i].v);
                  end
               end
            end

            if (!bus.cs_n)
               $display("cycle %0d: command %b a=%h ba=%b", c, got_cmd, bus.a, bus.ba);
            if (bus.ref_ack)
               $display("cycle %0d: refresh ack with req=%b", c, bus.ref_req);
         end
      end
   end

   initial begin
      // Hand-computed timeline: fields 0=cke 1=cmd 2=a 3=init_done 4=ref_req 5=ref_overrun
      add_pin(1, 0, 0);    add_pin(1, 1, 7);    add_pin(1, 3, 0);   add_pin(1, 4, 0);
      add_pin(12, 0, 0);   add_pin(13, 0, 1);   add_pin(13, 1, 7);
      add_pin(113, 1, 2);  add_pin(113, 2, 'h400); add_pin(114, 1, 7);
      add_pin(115, 1, 1);  add_pin(122, 1, 1);  add_pin(164, 1, 1);
      add_pin(171, 1, 0);  add_pin(171, 2, 'h37);
      add_pin(172, 3, 0);  add_pin(173, 3, 1);
      add_pin(952, 4, 0);  add_pin(953, 4, 1);
      add_pin(1732, 5, 0); add_pin(1733, 5, 1);
      add_pin(1740, 0, 0); add_pin(1740, 1, 7); add_pin(1740, 5, 0);
      add_pin(1747, 0, 0); add_pin(1748, 0, 1);
      add_pin(1860, 0, 0); add_pin(1860, 1, 7); add_pin(1860, 2, 0);
      add_pin(1866, 0, 0); add_pin(1867, 0, 1); add_pin(1967, 1, 2);
      add_pin(2026, 3, 0); add_pin(2027, 3, 1);
      add_pin(2806, 4, 0); add_pin(2807, 4, 1); add_pin(2810, 4, 1); add_pin(2811, 4, 0);
      add_pin(3587, 4, 1); add_pin(3591, 4, 0);
      add_pin(5147, 4, 1); add_pin(5147, 5, 0); add_pin(5151, 4, 0);
      add_pin(5301, 4, 0); add_pin(5927, 4, 1); add_pin(5931, 4, 0);
      add_pin(6002, 3, 1);
      add_pin(6003, 3, (WATCH != 0) ? 0 : 1);
      add_pin(6003, 0, (WATCH != 0) ? 0 : 1);
      add_pin(6012, 0, (WATCH != 0) ? 0 : 1);
      add_pin(6013, 0, 1);
      add_pin(6172, 3, (WATCH != 0) ? 0 : 1);
      add_pin(6173, 3, 1);
      add_pin(6200, 5, 0);

      rst_n       = 1'b0;
      pll_locked  = 1'b0;
      bus.ref_ack = 1'b0;

      goto(2);    rst_n = 1'b1;
      goto(10);   pll_locked = 1'b1;
      // Reset while in DONE (overrun set), then again inside the refresh loop.
      goto(1740); rst_n = 1'b0;
      goto(1743); rst_n = 1'b1;
      goto(1860); rst_n = 1'b0;
      goto(1862); rst_n = 1'b1;
      pulse_ack(2810);
      pulse_ack(3590);
      pulse_ack(5146);
      pulse_ack(5150);
      pulse_ack(5300);
      pulse_ack(5930);
      goto(6000); pll_locked = 1'b0;
      goto(6010); pll_locked = 1'b1;
      goto(END_CYC);
      @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
